// File: rtl/img_link_responder_pkg.sv
// Shared types for the image-link responder: FSM state encodings, link modes, default tokens.
// No logic; imported by the interface, the responder and its benches.
package img_link_responder_pkg;

    localparam int         ADDR_W_DEF   = 18;
    localparam logic [7:0] REQ_BYTE_DEF = 8'hF0;
    localparam logic [7:0] EOF_BYTE_DEF = 8'hFF;

    localparam logic MODE_SERVE   = 1'b0;
    localparam logic MODE_CAPTURE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_LOAD_EOF = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_TX  = 3'd5,
        ST_CAPT     = 3'd6
    } state_t;

endpackage

// File: rtl/img_link_responder_if.sv
// Byte-level link bundle: receiver handshake, transmitter handshake, source read port, capture write port.
// master = responder side, slave = receiver/transmitter/memories side.
interface img_link_responder_if
    import img_link_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rx_clr;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [ADDR_W-1:0] src_addr;
    logic [7:0]        src_q;
    logic [ADDR_W-1:0] cap_addr;
    logic [7:0]        cap_data;
    logic              cap_we;

    modport master (
        input  rx_data, rx_ready, tx_busy, src_q,
        output rx_clr, tx_data, tx_start, src_addr, cap_addr, cap_data, cap_we
    );

    modport slave (
        output rx_data, rx_ready, tx_busy, src_q,
        input  rx_clr, tx_data, tx_start, src_addr, cap_addr, cap_data, cap_we
    );
endinterface

// File: rtl/img_link_responder.sv
// Image-link peer: SERVE answers each REQ_BYTE with the next source byte (EOF_BYTE past the end), CAPTURE stores every rx byte.
// Latency: request consumed -> tx_start 3 cycles; rx byte consumed -> cap_we 1 cycle. Optional IMG_LINK_CHKSUM_EN adds chksum.
// Backpressure: rx bytes stay in the receiver until IDLE; tx_start held until tx_busy is seen high.
module img_link_responder
    import img_link_responder_pkg::*;
#(
    parameter int         ADDR_W   = ADDR_W_DEF,
    parameter logic [7:0] REQ_BYTE = REQ_BYTE_DEF,
    parameter logic [7:0] EOF_BYTE = EOF_BYTE_DEF
) (
    input  logic                clk_50m,
    input  logic                clear,
    input  logic                arm,
    input  logic                mode_sel,
    input  logic [ADDR_W-1:0]   img_len,
    img_link_responder_if.master link,
    output logic [ADDR_W-1:0]   byte_cnt,
    output logic                done,
    output logic                overrun
`ifdef IMG_LINK_CHKSUM_EN
    ,
    output logic [7:0]          chksum
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic              mode_q;
    logic [ADDR_W-1:0] len_q;
    logic              armed;
    logic [7:0]        rx_hold;
    logic [7:0]        tx_q;
    logic              cnt_full;
    logic              cnt_inc;
    logic              is_req;

    // done stays low out of reset until the first arm, so every output resets to 0
    assign cnt_full      = (byte_cnt == len_q);
    assign done          = armed & cnt_full;
    assign is_req        = (link.rx_data == REQ_BYTE);
    assign link.src_addr = byte_cnt;
    assign link.cap_addr = byte_cnt;
    assign link.cap_data = rx_hold;
    assign link.tx_data  = tx_q;

    always_ff @(posedge clk_50m or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (link.rx_ready) begin
                        if (mode_q == MODE_CAPTURE) begin
                            state_nxt = ST_CAPT;
                        end else if (is_req) begin
                            state_nxt = cnt_full ? ST_LOAD_EOF : ST_FETCH;
                        end
                    end
                end
                ST_FETCH:    state_nxt = ST_LOAD;
                ST_LOAD:     state_nxt = ST_SEND;
                ST_LOAD_EOF: state_nxt = ST_SEND;
                ST_SEND:     state_nxt = link.tx_busy ? ST_WAIT_TX : ST_SEND;
                ST_WAIT_TX:  state_nxt = link.tx_busy ? ST_WAIT_TX : ST_IDLE;
                ST_CAPT:     state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // EOF reaches WAIT_TX with the counter already full, so the saturation guard also skips it
    always_comb begin
        link.rx_clr   = 1'b0;
        link.tx_start = 1'b0;
        link.cap_we   = 1'b0;
        cnt_inc       = 1'b0;
        case (state)
            ST_IDLE:    link.rx_clr   = link.rx_ready & ~arm;
            ST_SEND:    link.tx_start = ~arm;
            ST_WAIT_TX: cnt_inc       = ~link.tx_busy & ~cnt_full & ~arm;
            ST_CAPT: begin
                link.cap_we = ~cnt_full & ~arm;
                cnt_inc     = ~cnt_full & ~arm;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50m or negedge clear) begin
        if (!clear) begin
            byte_cnt <= '0;
            overrun  <= 1'b0;
            mode_q   <= MODE_SERVE;
            len_q    <= '0;
            armed    <= 1'b0;
            rx_hold  <= 8'h00;
            tx_q     <= 8'h00;
        end else if (arm) begin
            byte_cnt <= '0;
            overrun  <= 1'b0;
            mode_q   <= mode_sel;
            len_q    <= img_len;
            armed    <= 1'b1;
        end else begin
            if (link.rx_clr) begin
                rx_hold <= link.rx_data;
            end
            if (state == ST_IDLE && link.rx_ready && mode_q == MODE_SERVE && !is_req) begin
                overrun <= 1'b1;
            end
            if (state == ST_LOAD) begin
                tx_q <= link.src_q;
            end
            if (state == ST_LOAD_EOF) begin
                tx_q    <= EOF_BYTE;
                overrun <= 1'b1;
            end
            if (state == ST_CAPT && cnt_full) begin
                overrun <= 1'b1;
            end
            if (cnt_inc) begin
                byte_cnt <= byte_cnt + ADDR_W'(1);
            end
        end
    end

`ifdef IMG_LINK_CHKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] inc_byte;

    assign inc_byte = (state == ST_CAPT) ? rx_hold : tx_q;
    assign chksum   = sum_q;

    always_ff @(posedge clk_50m or negedge clear) begin
        if (!clear) begin
            sum_q <= 8'h00;
        end else if (arm) begin
            sum_q <= 8'h00;
        end else if (cnt_inc) begin
            sum_q <= sum_q + inc_byte;
        end
    end
`endif

endmodule
